// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: datapath width,
// bubble encoding and the fetch FSM state type.
package instruction_fetch_unit_pkg;

    localparam int XLEN = 32;

    // addi x0,x0,0
    localparam logic [XLEN-1:0] NOP_ENCODING = 32'h0000_0013;

    typedef enum logic {
        FETCH,
        FLUSH
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_unit_fetch_fifo.sv
// Small synchronous FIFO holding fetched {instruction, pc} pairs.
// Head is read combinationally; clear has priority over push and pop.
module fetch_fifo
    import instruction_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 2 * XLEN,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             clear,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);

    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    // A push into a full FIFO is only honoured when the head leaves the same cycle.
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: PC, credit-limited memory requests, wrong-path
// discard after redirects and the IF/ID register. Define IF_PERF_CNT_EN to add perf counters.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR  = NOP_ENCODING
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic [31:0] IF_ID_IR,
    output logic [31:0] IF_ID_PC,
    output logic        IF_ID_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_bubble_cnt
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_EXT = (CW + 1)'(FIFO_DEPTH);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic [XLEN-1:0] if_id_ir_q, if_id_ir_d;
    logic [XLEN-1:0] if_id_pc_q, if_id_pc_d;
    logic            if_id_valid_q, if_id_valid_d;

    logic            req_hs;
    logic            rsp_hit;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_clear;
    logic [2*XLEN-1:0] fifo_head;
    logic [CW-1:0]   fifo_count;
    logic            fifo_empty;
    logic            fifo_full;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2 * XLEN)
    ) u_fetch_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ({imem_rsp_data, rsp_pc_q}),
        .pop       (fifo_pop),
        .clear     (fifo_clear),
        .head_data (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Credits cover both in-flight requests and buffered entries, so the FIFO never overflows.
    assign imem_req_valid = !rst && (state_q == FETCH) && !fifo_full &&
                            (({1'b0, outstanding_q} + {1'b0, fifo_count}) < DEPTH_EXT);
    assign imem_req_addr  = fetch_pc_q & ~32'h3;
    assign IF_ID_IR       = if_id_ir_q;
    assign IF_ID_PC       = if_id_pc_q;
    assign IF_ID_valid    = if_id_valid_q;

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        discard_d     = discard_q;
        if_id_ir_d    = if_id_ir_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_valid_d = if_id_valid_q;
        fifo_push     = 1'b0;
        fifo_pop      = 1'b0;
        fifo_clear    = 1'b0;

        req_hs  = imem_req_valid && imem_req_ready;
        rsp_hit = imem_rsp_valid && (outstanding_q != '0);
        outstanding_d = outstanding_q + CW'(req_hs) - CW'(rsp_hit);

        if (req_hs) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end

        if (redirect_en) begin
            // Everything still in flight, including a request leaving this cycle, is wrong-path.
            fifo_clear    = 1'b1;
            if_id_ir_d    = NOP_INSTR;
            if_id_valid_d = 1'b0;
            fetch_pc_d    = redirect_pc & ~32'h3;
            rsp_pc_d      = redirect_pc & ~32'h3;
            discard_d     = outstanding_d;
            state_d       = (outstanding_d != '0) ? FLUSH : FETCH;
        end else begin
            case (state_q)
                FETCH: begin
                    if (rsp_hit) begin
                        fifo_push = 1'b1;
                        rsp_pc_d  = rsp_pc_q + 32'd4;
                    end
                end
                FLUSH: begin
                    if (rsp_hit && (discard_q != '0)) begin
                        discard_d = discard_q - CW'(1);
                    end
                    if (discard_d == '0) begin
                        state_d = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase

            if (!stall) begin
                if (!fifo_empty) begin
                    fifo_pop      = 1'b1;
                    if_id_ir_d    = fifo_head[2*XLEN-1:XLEN];
                    if_id_pc_d    = fifo_head[XLEN-1:0];
                    if_id_valid_d = 1'b1;
                end else begin
                    if_id_ir_d    = NOP_INSTR;
                    if_id_valid_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FETCH;
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            if_id_ir_q    <= NOP_INSTR;
            if_id_pc_q    <= '0;
            if_id_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            if_id_ir_q    <= if_id_ir_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_bubble_q, perf_bubble_d;

    // A bubble is any unstalled IF/ID load that did not take an instruction, redirects included.
    always_comb begin
        perf_fetch_d  = perf_fetch_q + 32'(fifo_pop);
        perf_bubble_d = perf_bubble_q + 32'(!stall && !fifo_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_q  <= '0;
            perf_bubble_q <= '0;
        end else begin
            perf_fetch_q  <= perf_fetch_d;
            perf_bubble_q <= perf_bubble_d;
        end
    end

    assign perf_fetch_cnt  = perf_fetch_q;
    assign perf_bubble_cnt = perf_bubble_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: a latency-configurable memory
// model feeds responses, expected IF/ID entries are queued at request time.
`timescale 1ns/1ps
module tb_instruction_fetch_unit;

    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_en = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        stall = 1'b0;
    logic [31:0] IF_ID_IR;
    logic [31:0] IF_ID_PC;
    logic        IF_ID_valid;

    always #5 clk = ~clk;

    instruction_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (DEPTH),
        .NOP_INSTR  (NOP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_en    (redirect_en),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .IF_ID_IR       (IF_ID_IR),
        .IF_ID_PC       (IF_ID_PC),
        .IF_ID_valid    (IF_ID_valid)
    );

    typedef struct {
        int unsigned due;
        logic [31:0] addr;
    } pend_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
    } exp_t;

    pend_t pending[$];
    exp_t  sb[$];

    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;
    int unsigned lat = 1;
    int          ready_mode = 0;
    int unsigned edge_cnt = 0;
    int unsigned first_valid_edge = 0;
    int unsigned hs_count = 0;
    int unsigned valid_count = 0;
    logic        armed = 1'b0;
    logic        prev_rs = 1'b1;
    logic        prev_st = 1'b0;
    logic        prev_rd = 1'b0;
    logic [31:0] last_ir = '0;
    logic [31:0] last_pc = '0;
    logic        last_valid = 1'b0;
    logic [31:0] exp_pc = '0;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    // One clock cycle: check what the last edge produced, drive this cycle, record handshakes.
    task automatic applyStimulus(input logic rs, input logic st, input logic rd, input logic [31:0] rpc);
        pend_t p;
        exp_t  e;
        @(negedge clk);
        if (armed) begin
            if (prev_rs) begin
                checkOutput("rst_if_id_valid", 32'(IF_ID_valid), 32'd0);
                checkOutput("rst_if_id_ir", IF_ID_IR, NOP);
                checkOutput("rst_if_id_pc", IF_ID_PC, 32'd0);
            end else begin
                edge_cnt++;
                if (prev_rd) begin
                    checkOutput("redirect_valid", 32'(IF_ID_valid), 32'd0);
                    checkOutput("redirect_nop", IF_ID_IR, NOP);
                end else if (prev_st) begin
                    checkOutput("stall_hold_pc", IF_ID_PC, last_pc);
                    checkOutput("stall_hold_ir", IF_ID_IR, last_ir);
                    checkOutput("stall_hold_valid", 32'(IF_ID_valid), 32'(last_valid));
                end else if (IF_ID_valid) begin
                    valid_count++;
                    if (first_valid_edge == 0) first_valid_edge = edge_cnt;
                    if (sb.size() == 0) begin
                        checkOutput("unexpected_valid", 32'(IF_ID_valid), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        checkOutput("if_id_pc", IF_ID_PC, e.pc);
                        checkOutput("if_id_ir", IF_ID_IR, e.ir);
                    end
                end else begin
                    checkOutput("bubble_ir", IF_ID_IR, NOP);
                end
            end
        end
        armed      = 1'b1;
        last_ir    = IF_ID_IR;
        last_pc    = IF_ID_PC;
        last_valid = IF_ID_valid;

        rst         = rs;
        stall       = st;
        redirect_en = rd;
        redirect_pc = rpc;
        case (ready_mode)
            0:       imem_req_ready = 1'b1;
            1:       imem_req_ready = 1'($urandom_range(0, 1));
            default: imem_req_ready = 1'b0;
        endcase
        if (rs) begin
            pending.delete();
            sb.delete();
            exp_pc           = 32'h0;
            edge_cnt         = 0;
            first_valid_edge = 0;
            imem_rsp_valid   = 1'b0;
        end else if (pending.size() > 0 && pending[0].due <= cyc + 1) begin
            p              = pending.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memWord(p.addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
        if (rd) begin
            sb.delete();
            exp_pc = rpc & ~32'h3;
        end

        #1;
        if (rs) begin
            checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd0);
        end else if (imem_req_valid && imem_req_ready) begin
            hs_count++;
            pending.push_back('{due: cyc + 1 + lat, addr: imem_req_addr});
            if (!rd) begin
                checkOutput("req_addr", imem_req_addr, exp_pc);
                sb.push_back('{pc: exp_pc, ir: memWord(exp_pc)});
                exp_pc = exp_pc + 32'd4;
            end
            checkOutput("credit_bound", 32'(pending.size() <= DEPTH), 32'd1);
        end
        prev_rs = rs;
        prev_st = st;
        prev_rd = rd;
        @(posedge clk);
        cyc++;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic        found;
        int unsigned hs0;
        int unsigned vc0;

        // Reset, then single-cycle memory with decode always ready.
        lat        = 1;
        ready_mode = 0;
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        repeat (10) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("first_valid_edge", first_valid_edge, 32'd3);

        // Slow memory with a five-cycle decode stall and sporadic ready.
        lat        = 3;
        ready_mode = 1;
        repeat (6) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        hs0 = hs_count;
        repeat (5) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("stall_req_bound", 32'((hs_count - hs0) <= DEPTH), 32'd1);
        ready_mode = 0;
        repeat (12) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);

        // Redirect with two requests in flight.
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (pending.size() == 2) found = 1'b1;
            else applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        end
        checkOutput("two_outstanding_seen", 32'(found), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0100);
        repeat (15) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);

        // Redirect coinciding with a response and a request handshake.
        lat   = 1;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            #2;
            if (imem_req_valid && pending.size() > 0 && pending[0].due <= cyc + 1) found = 1'b1;
            else applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        end
        checkOutput("coincident_seen", 32'(found), 32'd1);
        vc0 = valid_count;
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0300);
        repeat (15) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("progress_after_redirect", 32'(valid_count > vc0), 32'd1);

        // Misaligned redirect target while decode is stalled.
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0203);
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        repeat (10) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);

        // PC wrap at the top of the address space.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        repeat (10) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);

        // Stop issuing and let everything in flight reach IF/ID.
        ready_mode = 2;
        repeat (20) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
        checkOutput("memory_drained", 32'(pending.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Front-end stage directly upstream of the decode stage. Owns the PC and issues word fetches to instruction memory over a valid/ready request channel with in-order responses.
- Buffers returned instructions in a small FIFO and drives the IF/ID pipeline register: instruction, PC and valid.
- Handles decode back-pressure (stall) and branch/jump redirects from execute, including discard of in-flight wrong-path responses.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FIFO_DEPTH, 2, instruction buffer entries; power of two, ≥2.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset: synchronous, active-high.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_req_addr  out  32  word-aligned fetch address.
- imem_rsp_valid  in  1  response valid; in request order; latency ≥1 cycle.
- imem_rsp_data  in  32  fetched instruction.
- redirect_en  in  1  taken branch/jump from execute.
- redirect_pc  in  32  redirect target.
- stall  in  1  decode cannot accept; hold IF/ID.
- IF_ID_IR  out  32  instruction to decode.
- IF_ID_PC  out  32  PC of IF_ID_IR.
- IF_ID_valid  out  1  IF_ID_IR is a real instruction.

Behaviour:
- Reset values (synchronous with rst=1): fetch_pc=RESET_PC, state=FETCH, FIFO empty, outstanding=0, discard=0, IF_ID_IR=NOP_INSTR, IF_ID_PC=0, IF_ID_valid=0, imem_req_valid=0. Reset asserted mid-operation abandons all in-flight responses; responses arriving after reset deassertion are not matched to requests, so memory must be reset together with this block.
- FSM states:
  - FETCH: imem_req_valid=1 when outstanding+fifo_count < FIFO_DEPTH. On req handshake: outstanding++, fetch_pc+=4 (wraps mod 2^32). imem_req_addr=fetch_pc with bits[1:0]=0.
  - FLUSH: imem_req_valid=0. Every response decrements discard; when discard reaches 0 (or is already 0), go to FETCH on the next cycle.
- Response in FETCH: pushed into FIFO as {data, pc}, outstanding--. FIFO cannot overflow, guaranteed by the credit rule.
- IF/ID update when stall=0:
  - FIFO non-empty: pop head into IF_ID_IR/IF_ID_PC, IF_ID_valid=1.
  - FIFO empty: IF_ID_IR=NOP_INSTR, IF_ID_valid=0, IF_ID_PC unchanged.
  - A response arriving into an empty FIFO is first visible in IF/ID one cycle later (fall-through not permitted).
  - Request-to-IF/ID latency = memory latency + 1 cycle.
- stall=1 and no redirect: IF/ID holds; FIFO holds; fetching continues until credits are exhausted.
- redirect_en=1 (priority over stall and all other events):
  - FIFO cleared; IF_ID_IR=NOP_INSTR, IF_ID_valid=0.
  - fetch_pc=redirect_pc with bits[1:0] forced to 0.
  - discard = outstanding, minus 1 if a response arrives this cycle, plus 1 if a request handshakes this cycle. The same-cycle response is dropped.
  - Next state is FLUSH if the resulting discard>0, else FETCH.
  - A redirect while in FLUSH recomputes discard by the same rule and updates fetch_pc.
- Simultaneous request handshake and response in FETCH: outstanding unchanged.
- Simultaneous push and pop: occupancy unchanged; head pops while the new entry enters the tail.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- Defined:
  - Adds output ports perf_fetch_cnt[31:0] and perf_bubble_cnt[31:0], both reset to 0 and wrapping.
  - perf_fetch_cnt increments on each IF/ID load with valid=1.
  - perf_bubble_cnt increments on each IF/ID load with valid=0 while stall=0.
- Undefined: ports and counters absent; functional behaviour identical.

Decomposition:
- Shared riscv package: NOP_INSTR encoding, XLEN=32, fetch FSM state enum {FETCH, FLUSH}.
- Sub-module fetch_fifo (parameterised depth/width, synchronous FIFO with push/pop/clear, count, empty/full).
- Top level holds the PC, FSM, credit/discard counters and the IF/ID register.

Test Plan:
- Reset then 1-cycle memory, stall=0 → requests to 0x0,0x4,0x8; IF_ID_PC sequence 0x0,0x4,0x8 with IF_ID_valid=1 from cycle 3 after reset release; IF_ID_IR matches memory.
- Stall held 5 cycles with 3-cycle memory → IF/ID frozen; at most FIFO_DEPTH outstanding+buffered; no request while credits=0; resumes in PC order, none lost or duplicated.
- Redirect to 0x100 with 2 responses outstanding → next IF/ID valid=0 with NOP 0x00000013; both stale responses discarded; first valid IF_ID_PC=0x100.
- Redirect in same cycle as a response and a request handshake → discard count correct; no wrong-path instruction reaches IF/ID; no deadlock.
- Redirect to 0x203 with stall=1 → fetch address 0x200; redirect beats stall; IF_ID_valid=0.
- fetch_pc=0xFFFFFFFC → next request addr 0x00000000 (wrap).
